// File: rtl/sadd_pkg.sv
// Shared types and defaults for the sadd word-level controller.
// Optional macro honoured by the users of this package: SADD_WORD_CTRL_CARRY_EN.
package sadd_pkg;

  localparam int unsigned SADD_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sadd_word_ctrl_if.sv
// Parallel request/result bus of sadd_word_ctrl.
// SADD_WORD_CTRL_CARRY_EN adds the cout result bit.
interface sadd_word_ctrl_if
  import sadd_pkg::*;
#(
  parameter int unsigned WIDTH = SADD_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
`ifdef SADD_WORD_CTRL_CARRY_EN
  logic             cout;

  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum);
  modport slave  (input start, a, b, output busy, done, sum);
`endif

endinterface

// File: rtl/sadd_shreg.sv
// Parallel-load, right-shift register; serial input enters at the MSB.
module sadd_shreg
  import sadd_pkg::*;
#(
  parameter int unsigned WIDTH = SADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sadd_word_ctrl.sv
// Word-level front end for the bit-serial adder sadd: serialises a/b LSB-first,
// gathers the serial sum. SADD_WORD_CTRL_CARRY_EN adds one carry-capture cycle and cout.
module sadd_word_ctrl
  import sadd_pkg::*;
#(
  parameter  int unsigned WIDTH = SADD_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  sadd_word_ctrl_if.slave        bus,
  output logic                   sadd_x,
  output logic                   sadd_y,
  output logic                   sadd_rst_b,
  input  logic                   sadd_s
);

`ifdef SADD_WORD_CTRL_CARRY_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, sum_sr, sum_r;
  logic             start_ok, shifting, last, sum_shift;
  logic             unused_ok;

  assign start_ok = (state == ST_IDLE) && bus.start;
  assign shifting = (state == ST_SHIFT);
  assign last     = shifting && (cnt == LAST_CNT);

`ifdef SADD_WORD_CTRL_CARRY_EN
  // The extra cycle carries the adder's carry-out; keep it out of the sum word.
  assign sum_shift = shifting && (cnt != LAST_CNT);
  assign unused_ok = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};
`else
  assign sum_shift = shifting;
  assign unused_ok = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1], sum_sr[0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bus.busy   = (state != ST_IDLE);
    bus.done   = (state == ST_DONE);
    sadd_x     = shifting & a_q[0];
    sadd_y     = shifting & b_q[0];
    sadd_rst_b = ~(rst | (state == ST_CLR));
    unique case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_CLR;
      ST_CLR:   state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == LAST_CNT) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_CLR) begin
      cnt <= '0;
    end else if (shifting) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef SADD_WORD_CTRL_CARRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r    <= '0;
      bus.cout <= 1'b0;
    end else if (last) begin
      sum_r    <= sum_sr;
      bus.cout <= sadd_s;
    end
  end
`else
  // Result takes the shift register's next value so the last serial bit lands with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r <= '0;
    end else if (last) begin
      sum_r <= {sadd_s, sum_sr[WIDTH-1:1]};
    end
  end
`endif

  assign bus.sum = sum_r;

  sadd_shreg #(.WIDTH(WIDTH)) u_a_sr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_ok),
    .shift (shifting),
    .sin   (1'b0),
    .d     (bus.a),
    .q     (a_q)
  );

  sadd_shreg #(.WIDTH(WIDTH)) u_b_sr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_ok),
    .shift (shifting),
    .sin   (1'b0),
    .d     (bus.b),
    .q     (b_q)
  );

  sadd_shreg #(.WIDTH(WIDTH)) u_sum_sr (
    .clk   (clk),
    .rst   (rst),
    .load  (1'b0),
    .shift (sum_shift),
    .sin   (sadd_s),
    .d     ('0),
    .q     (sum_sr)
  );

endmodule

// File: tb/tb_sadd_word_ctrl.sv
// Directed bench for sadd_word_ctrl (WIDTH=8) with a behavioural serial adder.
// Honours SADD_WORD_CTRL_CARRY_EN for cout and the longer latency.
module tb_sadd_word_ctrl;
  import sadd_pkg::*;

  localparam int unsigned W = 8;
`ifdef SADD_WORD_CTRL_CARRY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sadd_x, sadd_y, sadd_rst_b, sadd_s;
  logic carry;
  logic done_prev = 1'b0;
  int   tests = 0, fails = 0, cyc = 0, done_cnt = 0, dbl = 0, xy_bad = 0;

  sadd_word_ctrl_if #(.WIDTH(W)) bus ();

  sadd_word_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sadd_x     (sadd_x),
    .sadd_y     (sadd_y),
    .sadd_rst_b (sadd_rst_b),
    .sadd_s     (sadd_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Serial adder: Mealy sum, carry flop with active-low async reset.
  always @(posedge clk or negedge sadd_rst_b) begin
    if (!sadd_rst_b) carry <= 1'b0;
    else carry <= (sadd_x & sadd_y) | (sadd_x & carry) | (sadd_y & carry);
  end
  assign sadd_s = sadd_x ^ sadd_y ^ carry;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.done === 1'b1 && done_prev === 1'b1) dbl++;
    done_prev = bus.done;
    if ((bus.busy !== 1'b1 || bus.done === 1'b1 || sadd_rst_b === 1'b0) &&
        (sadd_x !== 1'b0 || sadd_y !== 1'b0)) xy_bad++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] expect_res(input logic [7:0] av, input logic [7:0] bv);
    logic [8:0] t;
    t = {1'b0, av} + {1'b0, bv};
    if (EXTRA == 0) t[8] = 1'b0;
    return t;
  endfunction

  // Issues one word; r = {cout (0 without carry feature), sum}, lat = edges after accept until done.
  task automatic do_word(input logic [7:0] av, input logic [7:0] bv, input bit hold,
                         output logic [8:0] r, output int lat, output int rstlow, output int e0);
    bit got;
    int w;
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    w = 0;
    do begin
      @(posedge clk);
      #1;
      w++;
    end while (sadd_rst_b !== 1'b0 && w < 50);
    e0 = cyc;
    if (!hold) bus.start = 1'b0;
    rstlow = 0;
    lat = 0;
    got = 1'b0;
    r = 'x;
    @(negedge clk);
    if (sadd_rst_b === 1'b0) rstlow++;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (sadd_rst_b === 1'b0) rstlow++;
      if (bus.done === 1'b1) begin
        got = 1'b1;
`ifdef SADD_WORD_CTRL_CARRY_EN
        r = {bus.cout, bus.sum};
`else
        r = {1'b0, bus.sum};
`endif
      end
    end
    if (!got) lat = -1;
  endtask

  initial begin
    logic [8:0] r;
    logic [7:0] av, bv;
    int lat, rl, e0a, e0b, dc0;

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_xy", {sadd_x, sadd_y}, 0);
    check("rst_sadd_rst_b", sadd_rst_b, 0);
`ifdef SADD_WORD_CTRL_CARRY_EN
    check("rst_cout", bus.cout, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("idle_sadd_rst_b", sadd_rst_b, 1);
    check("idle_busy", bus.busy, 0);

    do_word(8'h35, 8'h4A, 1'b0, r, lat, rl, e0a);
    check("t1_sum", r, 9'h07F);
    check("t1_latency", lat, W + 1 + EXTRA);
    check("t1_clr_cycles", rl, 1);

    do_word(8'hFF, 8'h01, 1'b0, r, lat, rl, e0a);
    check("t2_sum", r, (EXTRA != 0) ? 9'h100 : 9'h000);
    check("t2_latency", lat, W + 1 + EXTRA);

    do_word(8'h0F, 8'h01, 1'b1, r, lat, rl, e0a);
    check("b2b_w1_sum", r, 9'h010);
    do_word(8'h80, 8'h80, 1'b0, r, lat, rl, e0b);
    check("b2b_w2_sum", r, (EXTRA != 0) ? 9'h100 : 9'h000);
    check("b2b_issue_rate", e0b - e0a, W + 3 + EXTRA);
    check("b2b_clr_cycles", rl, 1);

    #2 dc0 = done_cnt;
    fork
      do_word(8'h12, 8'h34, 1'b0, r, lat, rl, e0a);
      begin
        repeat (4) @(negedge clk);
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.start = 1'b1;
        @(negedge clk);
        check("rp_busy", bus.busy, 1);
        bus.start = 1'b0;
      end
    join
    check("rp_sum", r, 9'h046);
    repeat (15) @(negedge clk);
    #2 check("rp_single_done", done_cnt - dc0, 1);

    dc0 = done_cnt;
    bus.a = 8'h33;
    bus.b = 8'h44;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ar_busy", bus.busy, 0);
    check("ar_sum", bus.sum, 0);
    check("ar_sadd_rst_b", sadd_rst_b, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    #2;
    check("ar_no_done", done_cnt - dc0, 0);
    check("ar_sum_held", bus.sum, 0);
    check("ar_idle", bus.busy, 0);
    do_word(8'h01, 8'h02, 1'b0, r, lat, rl, e0a);
    check("ar_next_sum", r, 9'h003);

    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      do_word(av, bv, 1'b0, r, lat, rl, e0a);
      check("rand_sum", r, expect_res(av, bv));
      check("rand_latency", lat, W + 1 + EXTRA);
    end

    #2;
    check("done_width", dbl, 0);
    check("xy_outside_shift", xy_bad, 0);
    check("done_total", done_cnt, 1006);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
